// File: rtl/cordic_arbiter_pkg.sv
// Shared CORDIC control definitions: arbiter state encoding, requester
// indices and the index width used for the CORDIC mux select.
package cordic_arbiter_pkg;

    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] GSO   = 3'd0;
    localparam logic [IDX_W-1:0] NORM  = 3'd1;
    localparam logic [IDX_W-1:0] UPDT  = 3'd2;
    localparam logic [IDX_W-1:0] EST   = 3'd3;
    localparam logic [IDX_W-1:0] CONV  = 3'd4;
    localparam logic [IDX_W-1:0] THETA = 3'd5;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Request/grant bundle between the CORDIC requesters and the arbiter.
interface cordic_arbiter_if
    import cordic_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 6
) ();

    logic [NUM_REQ-1:0] req;
    logic               err_clr;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   block;
    logic               mux_en;
    logic               busy;
    logic               timeout_err;
    logic [IDX_W-1:0]   err_id;

    modport master (
        output req, err_clr,
        input  gnt, block, mux_en, busy, timeout_err, err_id
    );

    modport slave (
        input  req, err_clr,
        output gnt, block, mux_en, busy, timeout_err, err_id
    );

endinterface

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import cordic_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 6
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int pos;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (!valid && mask[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin owner arbiter for the shared CORDIC core, with a post-release
// flush window and a tenure watchdog that masks runaway requesters.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 6,
    parameter int FLUSH_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    cordic_arbiter_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [15:0]      TENURE_MAX = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   last_owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [15:0]        tenure;
    logic [3:0]         flush_cnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   block;
    logic               mux_en;
    logic               busy;
    logic               timeout_err;
    logic [IDX_W-1:0]   err_id;
    logic               owner_req;
    logic               timeout;

    assign ptr       = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;
    assign eligible  = bus.req & ~mask;
    assign owner_req = bus.req[block];
    assign timeout   = (state == GRANT) && owner_req && (tenure == TENURE_MAX);

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .mask  (eligible),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            last_owner  <= LAST_IDX;
            tenure      <= '0;
            flush_cnt   <= '0;
            mask        <= '0;
            gnt         <= '0;
            block       <= '0;
            mux_en      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            // A mask bit survives only while its request stays high; a timeout sets it.
            mask <= (mask & bus.req) | (timeout ? (NUM_REQ'(1) << block) : '0);

            if (timeout) begin
                timeout_err <= 1'b1;
                err_id      <= block;
            end else if (bus.err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= GRANT;
                        gnt        <= NUM_REQ'(1) << pick_idx;
                        block      <= pick_idx;
                        mux_en     <= 1'b1;
                        busy       <= 1'b1;
                        tenure     <= '0;
                        last_owner <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!owner_req || timeout) begin
                        state     <= FLUSH;
                        gnt       <= '0;
                        mux_en    <= 1'b0;
                        flush_cnt <= '0;
                    end else begin
                        tenure <= tenure + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt;
    assign bus.block       = block;
    assign bus.mux_en      = mux_en;
    assign bus.busy        = busy;
    assign bus.timeout_err = timeout_err;
    assign bus.err_id      = err_id;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: grant-order scoreboard plus directed sequences.
module tb_cordic_arbiter;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    cordic_arbiter_if #(.NUM_REQ(6)) bus ();

    cordic_arbiter #(
        .NUM_REQ        (6),
        .FLUSH_CYCLES   (2),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] req;
        int         owner;
        int         tenure;
    } vec_t;

    vec_t       vecs[10];
    int         checks   = 0;
    int         failures = 0;
    int         exp_q[$];
    logic [5:0] prev_gnt = '0;
    int         hi;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock: sample on the falling edge, then score any new grant.
    task automatic cyc();
        int e;
        @(negedge clk);
        if (bus.gnt != '0)
            chk("gnt_onehot", int'($onehot(bus.gnt)), 1);
        if (bus.gnt != '0 && prev_gnt == '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant actual=%0d required=none", int'(bus.block));
            end else begin
                e = exp_q.pop_front();
                chk("sb_owner", int'(bus.block), e);
                chk("sb_gnt", int'(bus.gnt), 1 << e);
            end
        end
        prev_gnt = bus.gnt;
    endtask

    task automatic wait_grant();
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.gnt != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL grant_wait actual=none required=grant_within_40");
        end
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!bus.busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL idle_wait actual=busy required=idle_within_40");
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.err_clr = 1'b0;

        vecs[0] = '{6'b000001, 0, 2};
        vecs[1] = '{6'b000011, 1, 2};
        vecs[2] = '{6'b000011, 0, 2};
        vecs[3] = '{6'b100100, 2, 2};
        vecs[4] = '{6'b100100, 5, 3};
        vecs[5] = '{6'b111111, 0, 2};
        vecs[6] = '{6'b011000, 3, 2};
        vecs[7] = '{6'b000010, 1, 2};
        vecs[8] = '{6'b010001, 4, 3};
        vecs[9] = '{6'b000010, 1, 2};

        // Reset state
        #12;
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_block", int'(bus.block), 0);
        chk("rst_mux_en", int'(bus.mux_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_timeout_err", int'(bus.timeout_err), 0);
        chk("rst_err_id", int'(bus.err_id), 0);
        @(negedge clk);
        nrst = 1'b1;
        cyc();
        cyc();

        // First grant: one-cycle latency, then a two-cycle flush
        bus.req = 6'b000001;
        exp_q.push_back(0);
        chk("pre_grant_gnt", int'(bus.gnt), 0);
        cyc();
        chk("first_gnt", int'(bus.gnt), 1);
        chk("first_block", int'(bus.block), 0);
        chk("first_mux_en", int'(bus.mux_en), 1);
        chk("first_busy", int'(bus.busy), 1);
        bus.req = '0;
        cyc();
        chk("flush_gnt", int'(bus.gnt), 0);
        chk("flush_mux_en", int'(bus.mux_en), 0);
        chk("flush1_busy", int'(bus.busy), 1);
        cyc();
        chk("flush2_busy", int'(bus.busy), 1);
        cyc();
        chk("flush_end_busy", int'(bus.busy), 0);

        // Round-robin vector table
        for (int i = 0; i < 10; i++) begin
            bus.req = vecs[i].req;
            exp_q.push_back(vecs[i].owner);
            wait_grant();
            chk($sformatf("vec%0d_block", i), int'(bus.block), vecs[i].owner);
            repeat (vecs[i].tenure - 1) cyc();
            chk($sformatf("vec%0d_hold", i), int'(bus.gnt), 1 << vecs[i].owner);
            bus.req = '0;
            wait_idle();
        end

        // Alternation between owners 2 and 5 through the flush window
        bus.req = 6'b100100;
        exp_q.push_back(2);
        wait_grant();
        chk("alt_first_block", int'(bus.block), 2);
        repeat (2) cyc();
        bus.req = 6'b100000;
        exp_q.push_back(5);
        cyc();
        chk("alt_flush_gnt", int'(bus.gnt), 0);
        chk("alt_flush_block", int'(bus.block), 2);
        cyc();
        chk("alt_flush2_gnt", int'(bus.gnt), 0);
        cyc();
        chk("alt_idle_gnt", int'(bus.gnt), 0);
        cyc();
        chk("alt_second_gnt", int'(bus.gnt), 32);
        bus.req = 6'b100100;
        repeat (2) cyc();
        chk("alt_no_preempt", int'(bus.gnt), 32);
        bus.req = 6'b000100;
        exp_q.push_back(2);
        wait_grant();
        chk("alt_third_block", int'(bus.block), 2);
        bus.req = '0;
        wait_idle();

        // Tenure timeout on owner 3, held for 1100 cycles
        bus.req = 6'b001000;
        exp_q.push_back(3);
        hi = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            if (bus.gnt[3]) hi++;
        end
        chk("to_tenure_len", hi, 1024);
        chk("to_err", int'(bus.timeout_err), 1);
        chk("to_err_id", int'(bus.err_id), 3);
        chk("to_masked_gnt", int'(bus.gnt), 0);
        chk("to_masked_busy", int'(bus.busy), 0);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("clr_alone", int'(bus.timeout_err), 0);

        // Regrant after toggle; err_clr coincides with the second timeout
        bus.req = '0;
        cyc();
        bus.req = 6'b001000;
        exp_q.push_back(3);
        wait_grant();
        chk("regrant_block", int'(bus.block), 3);
        repeat (1023) cyc();
        chk("to2_last_cycle_gnt", int'(bus.gnt), 8);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("to2_gnt", int'(bus.gnt), 0);
        chk("set_wins", int'(bus.timeout_err), 1);
        chk("to2_err_id", int'(bus.err_id), 3);
        bus.req = '0;
        wait_idle();

        // Asynchronous reset in the middle of owner 4's tenure
        bus.req = 6'b010000;
        exp_q.push_back(4);
        wait_grant();
        chk("pre_rst_block", int'(bus.block), 4);
        cyc();
        #2 nrst = 1'b0;
        #1;
        chk("arst_gnt", int'(bus.gnt), 0);
        chk("arst_block", int'(bus.block), 0);
        chk("arst_mux_en", int'(bus.mux_en), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_timeout_err", int'(bus.timeout_err), 0);
        chk("arst_err_id", int'(bus.err_id), 0);
        bus.req = '0;
        @(negedge clk);
        nrst = 1'b1;
        cyc();
        // last_owner=5 makes the search start at 0, so 4 wins over 5
        bus.req = 6'b110000;
        exp_q.push_back(4);
        cyc();
        chk("post_rst_gnt", int'(bus.gnt), 16);
        bus.req = '0;
        wait_idle();

        // All requesters high, three-cycle tenures, full rotation
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        cyc();
        bus.req = 6'b111111;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(k % 6);
            wait_grant();
            chk($sformatf("rot%0d_block", k), int'(bus.block), k % 6);
            repeat (2) cyc();
            chk($sformatf("rot%0d_hold", k), int'(bus.gnt), 1 << (k % 6));
            bus.req = 6'b111111 & ~(6'b000001 << (k % 6));
            cyc();
            bus.req = 6'b111111;
        end
        bus.req = '0;
        wait_idle();

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 6, giving the requester count (0 GSO, 1 NORM, 2 UPDT, 3 EST, 4 CONV, 5 THETA).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of post-release CORDIC quiet cycles (range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum grant tenure in cycles (range 2..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: level request per requester, held high for the whole tenure.
REQ-007 The block SHALL have port err_clr, input, 1 bit: single-cycle clear of timeout_err.
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant.
REQ-009 The block SHALL have port block, output, 3 bits: owner index driving the CORDIC mux select.
REQ-010 The block SHALL have port mux_en, output, 1 bit: CORDIC mux enable.
REQ-011 The block SHALL have port busy, output, 1 bit: high when not IDLE.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: sticky tenure-overrun flag.
REQ-013 The block SHALL have port err_id, output, 3 bits: requester index of the last timeout.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT and FLUSH, and all outputs SHALL be registered.
REQ-015 In IDLE with any eligible req bit high at edge N, the FSM SHALL enter GRANT at edge N, and gnt, block and mux_en SHALL be valid after edge N, i.e. 1-cycle grant latency.
REQ-016 Arbitration SHALL be round-robin: the search starts at (last_owner+1) mod NUM_REQ, and last_owner updates on each grant.
REQ-017 In GRANT, gnt SHALL hold exactly one bit, block SHALL equal the owner index, and mux_en SHALL be 1.
REQ-018 In GRANT, when req[owner] is sampled 0, the FSM SHALL enter FLUSH with gnt=0 and mux_en=0; block SHALL hold its last value.
REQ-019 FLUSH SHALL last exactly FLUSH_CYCLES cycles and then return to IDLE; requests arriving during FLUSH SHALL wait.
REQ-020 The tenure counter SHALL be 16 bits, cleared on grant and incremented each GRANT cycle; reaching TIMEOUT_CYCLES-1 with req[owner] still 1 SHALL force FLUSH, set timeout_err and load err_id with the owner.
REQ-021 A timed-out requester SHALL be masked (ineligible) until its req bit has been sampled 0 at least once.
REQ-022 Requests from non-owners during GRANT SHALL be ignored, with no preemption.
REQ-023 If err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-024 A request dropped in the same cycle as the IDLE arbitration edge SHALL NOT be granted, because only the sampled value counts.

Reset
REQ-025 Asserting nrst SHALL immediately force IDLE with gnt=0, block=0, mux_en=0, busy=0, timeout_err=0, err_id=0, counters=0, last_owner=NUM_REQ-1 and masks cleared.
REQ-026 Reset during GRANT or FLUSH SHALL abort the tenure with no FLUSH sequence, and the first post-reset grant SHALL follow REQ-015.

Structure
REQ-027 The state encoding, the requester index constants (GSO..THETA) and the index width SHALL reside in the shared CORDIC control package.
REQ-028 The round-robin priority picker SHALL be one combinational sub-module, rr_pick (inputs: req mask, pointer; outputs: index, valid).

Verification
REQ-029 Reset, then req=6'b000001 at cycle 3 -> gnt=000001, block=0, mux_en=1 from cycle 4.
REQ-030 req=6'b100100 held with owner 2 releasing -> after 2 FLUSH cycles owner 5 is granted, then owner 2 next, confirming alternation.
REQ-031 Owner 3 holds req for 1100 cycles with TIMEOUT_CYCLES=1024 -> FLUSH at tenure cycle 1023, timeout_err=1, err_id=3, and req[3] is not regranted until it toggles low.
REQ-032 nrst pulsed low mid-GRANT (owner 4) -> all outputs 0 asynchronously, last_owner=5, and the next req=010000 is granted owner 4.
REQ-033 err_clr and a timeout in the same cycle -> timeout_err stays 1; err_clr alone -> timeout_err=0 the next cycle.
REQ-034 All six req bits high continuously with 3-cycle tenures -> grants follow the sequence 0,1,2,3,4,5,0, and gnt is never multi-hot.
